// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector of a combinational DUT,
// records its output into a truth table and flags the first disagreement.
module truth_table_sweeper #(
    parameter int  N_IN  = 4,
    parameter int  DWELL = 20,
    localparam int T     = 1 << N_IN,
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic            hold,
    input  logic [T-1:0]    exp_tt,
    input  logic            f_in,
    output logic [N_IN-1:0] stim,
    output logic [T-1:0]    tt,
    output logic            busy,
    output logic            done,
    output logic            mismatch,
    output logic [N_IN-1:0] fail_idx
);

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]   DWELL_ONE  = CW'(1);
    localparam logic [N_IN-1:0] STIM_LAST  = '1;
    localparam logic [N_IN-1:0] STIM_ONE   = N_IN'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [T-1:0]    tt_q, tt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mismatch_q, mismatch_d;
    logic [N_IN-1:0] fail_idx_q, fail_idx_d;

    always_comb begin
        state_d     = state_q;
        dwell_cnt_d = dwell_cnt_q;
        stim_d      = stim_q;
        tt_d        = tt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mismatch_d  = mismatch_q;
        fail_idx_d  = fail_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SWEEP;
                    busy_d      = 1'b1;
                    stim_d      = '0;
                    dwell_cnt_d = '0;
                    tt_d        = '0;
                    mismatch_d  = 1'b0;
                    fail_idx_d  = '0;
                end
            end
            ST_SWEEP: begin
                // Nothing moves while held; a pending capture simply waits.
                if (!hold) begin
                    if (dwell_cnt_q != DWELL_LAST) begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
                    end else begin
                        dwell_cnt_d  = '0;
                        tt_d[stim_q] = f_in;
                        if ((f_in != exp_tt[stim_q]) && !mismatch_q) begin
                            mismatch_d = 1'b1;
                            fail_idx_d = stim_q;
                        end
                        stim_d = stim_q + STIM_ONE;
                        if (stim_q == STIM_LAST) begin
                            done_d = 1'b1;
                            if (!mode) begin
                                busy_d  = 1'b0;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dwell_cnt_q <= '0;
            stim_q      <= '0;
            tt_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            fail_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            stim_q      <= stim_d;
            tt_q        <= tt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            fail_idx_q  <= fail_idx_d;
        end
    end

    assign stim     = stim_q;
    assign tt       = tt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign mismatch = mismatch_q;
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised bench for truth_table_sweeper: a 4-input/20-dwell instance and a
// 2-input/1-dwell instance, checked against a vector-count based reference model.
module tb_truth_table_sweeper;

    localparam int NI  = 4;
    localparam int DW  = 20;
    localparam int TS  = 16;
    localparam int DW2 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mode, hold;
    logic [15:0] exp_tt, lut;
    logic        f_in;
    logic [3:0]  stim, fail_idx;
    logic [15:0] tt;
    logic        busy, done, mismatch;

    logic        start2;
    logic [3:0]  exp_tt2, lut2;
    logic        f_in2;
    logic [1:0]  stim2, fail_idx2;
    logic [3:0]  tt2;
    logic        busy2, done2, mismatch2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Combinational "lab DUTs" are just lookup tables indexed by the stimulus.
    assign f_in  = lut[stim];
    assign f_in2 = lut2[stim2];

    truth_table_sweeper #(.N_IN(NI), .DWELL(DW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
        .exp_tt(exp_tt), .f_in(f_in), .stim(stim), .tt(tt), .busy(busy),
        .done(done), .mismatch(mismatch), .fail_idx(fail_idx)
    );

    truth_table_sweeper #(.N_IN(2), .DWELL(DW2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(1'b0), .hold(1'b0),
        .exp_tt(exp_tt2), .f_in(f_in2), .stim(stim2), .tt(tt2), .busy(busy2),
        .done(done2), .mismatch(mismatch2), .fail_idx(fail_idx2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Lowest index among the first c captured vectors where table and expectation differ.
    function automatic int first_bad(input logic [15:0] a, input logic [15:0] b, input int c, input int tsz);
        int lim = (c > tsz) ? tsz : c;
        for (int i = 0; i < lim; i++) begin
            if (a[i] != b[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] low_mask(input int c, input int tsz);
        logic [31:0] m;
        if (c >= tsz) c = tsz;
        m = (32'd1 << c) - 32'd1;
        return m[15:0];
    endfunction

    task automatic run_sweep(input logic [15:0] lut_v, input logic [15:0] exp_v, input int nsw,
                             input int hold_at, input int hold_len, input bit poke_start);
        int   active = 0;
        int   n = 0;
        int   c, fb, sweeps;
        int   limit = nsw * TS * DW + hold_len + 20;
        bit   fin = 0;
        bit   was_hold, want_done;
        lut    = lut_v;
        exp_tt = exp_v;
        mode   = (nsw > 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t0_busy", 32'(busy), 32'd1);
        check("t0_stim", 32'(stim), 32'd0);
        check("t0_tt", 32'(tt), 32'd0);
        check("t0_mismatch", 32'(mismatch), 32'd0);
        while (!fin) begin
            n++;
            hold     = (n >= hold_at) && (n < hold_at + hold_len);
            start    = poke_start && ($urandom_range(0, 7) == 0);
            was_hold = hold;
            @(posedge clk);
            #1;
            if (!was_hold) active++;
            c         = active / DW;
            sweeps    = active / (TS * DW);
            want_done = !was_hold && (active % (TS * DW) == 0);
            fb        = first_bad(lut_v, exp_v, c, TS);
            check("done", 32'(done), 32'(want_done));
            check("stim", 32'(stim), 32'(c % TS));
            check("tt", 32'(tt), 32'(lut_v & low_mask(c, TS)));
            check("busy", 32'(busy), 32'(sweeps < nsw));
            check("mismatch", 32'(mismatch), 32'(fb >= 0));
            check("fail_idx", 32'(fail_idx), (fb >= 0) ? 32'(fb) : 32'd0);
            if (want_done) begin
                $display("[TB] sweep %0d/%0d lut=%h exp=%h tt=%h mismatch=%0d fail_idx=%0d cycles=%0d",
                         sweeps, nsw, lut_v, exp_v, tt, mismatch, fail_idx, n);
                mode = (sweeps < nsw - 1);
                if (sweeps >= nsw) fin = 1;
            end
            if (!fin && n > limit) begin
                check("sweep_timeout", 32'd0, 32'd1);
                fin = 1;
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        mode  = 1'b0;
        @(posedge clk);
        #1;
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_tt", 32'(tt), 32'(lut_v));
    endtask

    task automatic run_reset_abort(input logic [15:0] lut_v);
        lut    = lut_v;
        exp_tt = lut_v ^ 16'h0001;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9 * DW) @(posedge clk);
        #1;
        check("pre_rst_stim", 32'(stim), 32'd9);
        check("pre_rst_mismatch", 32'(mismatch), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_tt", 32'(tt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("rst_idle_done", 32'(done), 32'd0);
            check("rst_idle_busy", 32'(busy), 32'd0);
        end
        $display("[TB] reset abort at stim=9 lut=%h", lut_v);
    endtask

    task automatic run_small(input logic [3:0] lut_v, input logic [3:0] exp_v);
        int fb;
        lut2    = lut_v;
        exp_tt2 = exp_v;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("s_t0_stim", 32'(stim2), 32'd0);
        check("s_t0_busy", 32'(busy2), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            fb = first_bad({12'd0, lut_v}, {12'd0, exp_v}, k, 4);
            check("s_stim", 32'(stim2), 32'(k % 4));
            check("s_done", 32'(done2), 32'(k == 4));
            check("s_busy", 32'(busy2), 32'(k < 4));
            check("s_tt", 32'(tt2), 32'({12'd0, lut_v} & low_mask(k, 4)));
            check("s_mismatch", 32'(mismatch2), 32'(fb >= 0));
            check("s_fail_idx", 32'(fail_idx2), (fb >= 0) ? 32'(fb) : 32'd0);
        end
        $display("[TB] small sweep lut=%h exp=%h tt=%h mismatch=%0d fail_idx=%0d",
                 lut_v, exp_v, tt2, mismatch2, fail_idx2);
    endtask

    initial begin
        logic [15:0] l, m;
        int sel, nsw, hl, ha;
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; hold = 1'b0;
        exp_tt = '0; lut = '0;
        start2 = 1'b0; exp_tt2 = '0; lut2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stim", 32'(stim), 32'd0);
        check("reset_tt", 32'(tt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_mismatch", 32'(mismatch), 32'd0);
        check("reset_fail_idx", 32'(fail_idx), 32'd0);
        check("reset2_busy", 32'(busy2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_sweep(16'h55AA, 16'h55AA, 1, 0, 0, 0);
        run_sweep(16'h55AA, 16'h55AB, 1, 0, 0, 0);
        run_sweep(16'h55AA, 16'h45AB, 1, 0, 0, 0);
        run_sweep(16'h55AA, 16'h55AA, 1, 3 * DW + 5, 7, 0);
        run_sweep(16'h55AA, 16'h55AA, 2, 0, 0, 1);
        run_reset_abort(16'h55AA);
        run_sweep(16'h55AA, 16'h55AA, 1, 0, 0, 0);

        repeat (6) begin
            l   = 16'($urandom);
            sel = $urandom_range(0, 2);
            m   = (sel == 0) ? 16'd0 : (sel == 1) ? 16'(32'd1 << $urandom_range(0, 15)) : 16'($urandom);
            nsw = $urandom_range(1, 2);
            hl  = $urandom_range(0, 12);
            ha  = $urandom_range(1, TS * DW - 20);
            run_sweep(l, l ^ m, nsw, ha, hl, $urandom_range(0, 1) == 1);
        end

        run_small(4'h8, 4'h8);
        repeat (6) begin
            lut2 = 4'($urandom);
            run_small(lut2, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Parametrised exhaustive-stimulus engine for combinational lab DUTs of N_IN inputs and one output.
- Drives every input combination 0..2^N_IN-1 in ascending order, holding each for DWELL clocks.
- Captures the DUT output per vector into a truth-table register and compares it against an expected table.
- Adds what a hand-written stimulus sequence lacks: pause (hold), continuous sweep mode and a first-failure report.
- Sits between a synthesised DUT and board LEDs/switches or a top-level self-checking bench.

Parameters:
N_IN, 4, number of DUT inputs (1..8); table size T = 2^N_IN.
DWELL, 20, clock cycles each vector is held before sampling (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin sweep; honoured only when busy=0.
mode  input  1  0 = single sweep, 1 = continuous; sampled at each sweep end.
hold  input  1  freezes dwell counter and stim while high.
exp_tt  input  T  expected DUT output; bit i = expected f for stim=i.
f_in  input  1  DUT output.
stim  output  N_IN  DUT input vector; MSB = first DUT input (A).
tt  output  T  captured truth table; bit i = f_in sampled for stim=i.
busy  output  1  high while sweeping.
done  output  1  one-cycle pulse at end of every sweep.
mismatch  output  1  sticky; set on first tt/exp_tt disagreement since start.
fail_idx  output  N_IN  stim value of the first mismatch.

Behaviour:
- Reset (clk edge with rst=1, overrides everything):
  - Outputs: stim=0, tt=0, busy=0, done=0, mismatch=0, fail_idx=0.
  - Internal state: FSM=IDLE, dwell_cnt=0.
  - Reset mid-sweep aborts immediately; no done pulse.
- FSM states IDLE and SWEEP.
- IDLE, start=1 at edge t0:
  - Sets busy=1, stim=0, dwell_cnt=0, tt=0, mismatch=0, fail_idx=0.
  - Transitions to SWEEP.
- SWEEP, hold=0, each edge:
  - If dwell_cnt < DWELL-1: dwell_cnt++.
  - Else capture edge:
    - tt[stim] <= f_in.
    - If f_in != exp_tt[stim] and mismatch=0: mismatch<=1, fail_idx<=stim.
    - dwell_cnt<=0.
    - If stim < T-1: stim++.
- Sweep end: capture edge with stim = T-1.
  - done<=1 for exactly one cycle.
  - stim wraps to 0.
  - mode=1: remain in SWEEP; tt overwritten bit-by-bit; mismatch/fail_idx keep sticky history.
  - mode=0: busy<=0 and go to IDLE. tt, mismatch and fail_idx hold until next start or rst.
- hold=1 in SWEEP:
  - dwell_cnt, stim, tt and mismatch all frozen.
  - Any capture edge is deferred until hold=0.
  - hold ignored in IDLE.
- Timing and start handling:
  - Each vector is stable for exactly DWELL cycles before its capture edge.
  - Un-held sweep: done asserted in the cycle after edge t0 + T*DWELL.
  - start while busy=1 is ignored, including during the done cycle in continuous mode.
  - start and rst together: rst wins.
- Widths:
  - dwell_cnt sized ceil(log2(DWELL)), minimum 1 bit.
  - stim increment wraps modulo T; there is no overflow flag.

Test Plan:
1. N_IN=4, DWELL=20; bench models f_in = stim[3]^stim[0]; exp_tt=16'h55AA; pulse start → stim steps 0..15 every 20 clk; done after 320 clk; tt=16'h55AA, mismatch=0, busy falls with done.
2. Same DUT, exp_tt=16'h55AB → tt=16'h55AA, mismatch=1, fail_idx=0; second error bit 16'h45AB also → fail_idx still 0 (first only).
3. hold=1 for 7 clk while stim=3 → stim stays 3, tt unchanged during hold; done arrives at 327 clk; tt=16'h55AA.
4. mode=1 → done pulses at 320 and 640 clk; stim wraps 15→0; start pulses mid-sweep ignored; drop mode before 640 → busy=0 after second done.
5. rst=1 at stim=9 → next cycle stim=0, tt=0, busy=0, no done; a new start completes a normal 320 clk sweep.
6. N_IN=2, DWELL=1, f_in = stim[1]&stim[0], exp_tt=4'h8 → stim changes every clk; done after 4 clk; tt=4'h8, mismatch=0.
